// File: rtl/maltsev_pkg.sv
// Shared definitions for the Maltsev operation units and their sequencers.
//
// Contents:
//   ST_IDLE..ST_DONE : 3-bit state encodings of the iteration sequencer
//   state_t          : enumerated sequencer state built on those encodings
//   MALTSEV_BW       : default operand/result width
//   MALTSEV_CW       : default iteration-count width
package maltsev_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam int MALTSEV_BW = 16;
    localparam int MALTSEV_CW = 16;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_ISSUE   = ST_ISSUE,
        S_WAIT    = ST_WAIT,
        S_RELEASE = ST_RELEASE,
        S_DONE    = ST_DONE
    } state_t;

endpackage

// File: rtl/operation_s_16.sv
// Successor operation unit: RES = IN + 1 (modulo 2^16), responder side of
// the four-phase ST/RD handshake.
//
// Handshake: the initiator raises ST with IN stable; this unit captures
// IN + 1 and raises RD on the next edge; once ST is seen low, RD drops on
// the following edge. RES holds its value until the next capture.
//
// Ports:
//   CLK  in   clock, rising edge
//   RST  in   synchronous active-high reset
//   ST   in   start from initiator
//   IN   in   16-bit operand
//   RD   out  ready, RES valid while high
//   RES  out  16-bit successor of IN
module operation_s_16 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ST,
    input  logic [15:0] IN,
    output logic        RD,
    output logic [15:0] RES
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            RD  <= 1'b0;
            RES <= 16'd0;
        end else if (!RD && ST) begin
            RES <= IN + 16'd1;   // 0xFFFF wraps to 0x0000
            RD  <= 1'b1;
        end else if (RD && !ST) begin
            RD  <= 1'b0;
        end
    end

endmodule

// File: rtl/op_iterate_16.sv
// Iteration sequencer: accepts an operand IN and a count N over an upstream
// four-phase handshake, applies a downstream single-operand unit N times
// (feeding each result back as the next operand) and returns the final
// value on RES.
//
// Handshake (both sides): initiator raises ST with the operand stable;
// responder raises RD with the result stable; initiator drops ST;
// responder drops RD.
//
// Ports:
//   CLK     in   clock, rising edge
//   RST     in   synchronous active-high reset
//   ST      in   upstream start
//   IN      in   upstream operand (sampled when a start is accepted)
//   N       in   iteration count  (sampled when a start is accepted)
//   RD      out  upstream ready, RES valid while high
//   RES     out  upstream result (always the accumulator)
//   BUSY    out  high outside IDLE
//   OP_ST   out  downstream start
//   OP_IN   out  downstream operand (always the accumulator)
//   OP_RD   in   downstream ready
//   OP_RES  in   downstream result
module op_iterate_16
    import maltsev_pkg::*;
#(
    parameter int BW = MALTSEV_BW,
    parameter int CW = MALTSEV_CW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ST,
    input  logic [BW-1:0] IN,
    input  logic [CW-1:0] N,
    output logic          RD,
    output logic [BW-1:0] RES,
    output logic          BUSY,
    output logic          OP_ST,
    output logic [BW-1:0] OP_IN,
    input  logic          OP_RD,
    input  logic [BW-1:0] OP_RES
);

    state_t        state, state_next;
    logic [BW-1:0] acc, acc_next;
    logic [CW-1:0] cnt, cnt_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (ST) begin
                    acc_next   = IN;
                    cnt_next   = N;
                    state_next = (N == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Never capture here: OP_RD may still be the tail of an
                // earlier call only if RELEASE was skipped, which it never is.
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (OP_RD) begin
                    acc_next   = OP_RES;
                    cnt_next   = cnt - 1'b1;
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Wait for the responder to finish its handshake before
                // deciding, so the next ISSUE starts with OP_RD low.
                if (!OP_RD) begin
                    state_next = (cnt == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                if (!ST) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // All outputs decode the registered state/accumulator only.
    assign RD    = (state == S_DONE);
    assign BUSY  = (state != S_IDLE);
    assign OP_ST = (state == S_ISSUE) || (state == S_WAIT);
    assign OP_IN = acc;
    assign RES   = acc;

endmodule

// File: tb/tb_op_iterate_16.sv
module tb_op_iterate_16;

    logic        clk;
    logic        rst;
    logic        st;
    logic [15:0] in_v;
    logic [15:0] n_v;
    logic        rd;
    logic [15:0] res;
    logic        busy;
    logic        op_st;
    logic [15:0] op_in;
    logic        op_rd;
    logic [15:0] op_res;

    // Real successor unit and a behavioural responder with random latency.
    logic        s_rd;
    logic [15:0] s_res;
    logic        m_rd;
    logic [15:0] m_res;
    logic        use_model;

    int n_cmp;
    int n_err;

    logic [15:0] exp_q[$];     // expected downstream operands
    logic [15:0] issued_q[$];  // observed downstream operands (one per OP_ST rise)
    int          stale_cnt;
    logic        prev_op_st;

    assign op_rd  = use_model ? m_rd  : s_rd;
    assign op_res = use_model ? m_res : s_res;

    op_iterate_16 #(.BW(16), .CW(16)) dut (
        .CLK   (clk),
        .RST   (rst),
        .ST    (st),
        .IN    (in_v),
        .N     (n_v),
        .RD    (rd),
        .RES   (res),
        .BUSY  (busy),
        .OP_ST (op_st),
        .OP_IN (op_in),
        .OP_RD (op_rd),
        .OP_RES(op_res)
    );

    operation_s_16 succ (
        .CLK(clk),
        .RST(rst),
        .ST (op_st),
        .IN (op_in),
        .RD (s_rd),
        .RES(s_res)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: log each downstream start and flag starts made over a stale ready.
    initial begin
        prev_op_st = 1'b0;
        forever begin
            @(negedge clk);
            if (op_st && !prev_op_st) begin
                issued_q.push_back(op_in);
                if (op_rd) stale_cnt++;
            end
            prev_op_st = op_st;
        end
    end

    // Behavioural responder: successor with random latency L and release delay R.
    initial begin
        int lat;
        int rel;
        int k;
        m_rd  = 1'b0;
        m_res = 16'd0;
        forever begin
            @(negedge clk);
            if (use_model && op_st && !m_rd) begin
                lat = $urandom_range(0, 5);
                rel = $urandom_range(0, 3);
                repeat (lat) @(negedge clk);
                m_res = op_in + 16'd1;
                m_rd  = 1'b1;
                k = 0;
                while (op_st && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                repeat (rel) @(negedge clk);
                m_rd = 1'b0;
            end
        end
    end

    // Reference model: N applications of the successor.
    task automatic model_run(input logic [15:0] a, input logic [15:0] n,
                             output logic [15:0] final_v);
        logic [15:0] v;
        exp_q.delete();
        v = a;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(v);
            v = v + 16'd1;
        end
        final_v = v;
    endtask

    // Driver: start a run and wait (bounded) for RD. ST is left high.
    task automatic start_run(input logic [15:0] a, input logic [15:0] n,
                             input int budget, output int cycles);
        issued_q.delete();
        stale_cnt = 0;
        @(negedge clk);
        st   = 1'b1;
        in_v = a;
        n_v  = n;
        cycles = 0;
        while (!rd && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic drop_st();
        st = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        st  = 1'b1;
        in_v = 16'd5;
        n_v  = 16'd0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({rd, op_st, busy} !== 3'b000 || res !== 16'd0 || op_in !== 16'd0) begin
                n_err++;
                $display("FAIL reset_outputs cyc%0d: rd=%b op_st=%b busy=%b res=%h op_in=%h, want all 0",
                         c, rd, op_st, busy, res, op_in);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || rd !== 1'b1 || res !== 16'd5) begin
            n_err++;
            $display("FAIL reset_first_start: busy=%b rd=%b res=%h, want busy=1 rd=1 res=0005", busy, rd, res);
        end
        drop_st();
        n_cmp++;
        if (rd !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_return_idle: rd=%b busy=%b, want 0 0", rd, busy);
        end
    endtask

    task automatic check_run(input string name, input logic [15:0] a, input logic [15:0] n,
                             input int budget);
        logic [15:0] exp_res;
        int cyc;
        model_run(a, n, exp_res);
        start_run(a, n, budget, cyc);
        n_cmp++;
        if (rd !== 1'b1) begin
            n_err++;
            $display("FAIL %s_timeout: rd=%b after %0d cycles, want 1", name, rd, cyc);
        end
        n_cmp++;
        if (res !== exp_res) begin
            n_err++;
            $display("FAIL %s_res: got %h, want %h", name, res, exp_res);
        end
        n_cmp++;
        if (issued_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s_pulses: got %0d op_st pulses, want %0d", name, issued_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (issued_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL %s_op_in[%0d]: got %h, want %h", name, i, issued_q[i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (stale_cnt != 0) begin
            n_err++;
            $display("FAIL %s_stale_start: %0d starts over high op_rd, want 0", name, stale_cnt);
        end
    endtask

    task automatic test_basic();
        check_run("basic", 16'd2, 16'd3, 500);
        // RD must hold while ST stays high.
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if (rd !== 1'b1 || res !== 16'd5 || op_st !== 1'b0) begin
                n_err++;
                $display("FAIL basic_hold: rd=%b res=%h op_st=%b, want 1 0005 0", rd, res, op_st);
            end
        end
        drop_st();
        n_cmp++;
        if (rd !== 1'b0) begin
            n_err++;
            $display("FAIL basic_rd_fall: rd=%b, want 0", rd);
        end
    endtask

    task automatic test_zero_count();
        logic [15:0] exp_res;
        int cyc;
        model_run(16'd7, 16'd0, exp_res);
        start_run(16'd7, 16'd0, 2, cyc);
        n_cmp++;
        if (rd !== 1'b1 || res !== exp_res) begin
            n_err++;
            $display("FAIL zero_count: rd=%b res=%h after %0d cycles, want rd=1 res=%h", rd, res, cyc, exp_res);
        end
        n_cmp++;
        if (issued_q.size() != 0) begin
            n_err++;
            $display("FAIL zero_count_pulses: got %0d, want 0", issued_q.size());
        end
        drop_st();
    endtask

    task automatic test_wrap();
        check_run("wrap", 16'hFFFE, 16'd3, 500);
        drop_st();
    endtask

    task automatic test_random_latency();
        use_model = 1'b1;
        @(negedge clk);
        check_run("rand100", 16'd100, 16'd10, 2000);
        drop_st();
        for (int t = 0; t < 6; t++) begin
            logic [15:0] a;
            logic [15:0] n;
            a = 16'($urandom);
            n = 16'($urandom_range(1, 8));
            check_run($sformatf("rand%0d", t), a, n, 2000);
            drop_st();
        end
        use_model = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int k;
        issued_q.delete();
        @(negedge clk);
        st   = 1'b1;
        in_v = 16'd0;
        n_v  = 16'd5;
        k = 0;
        while (!op_st && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);  // now waiting on the downstream unit
        st  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (op_st !== 1'b0 || busy !== 1'b0 || rd !== 1'b0 || res !== 16'd0) begin
            n_err++;
            $display("FAIL midrun_reset: op_st=%b busy=%b rd=%b res=%h, want 0 0 0 0000", op_st, busy, rd, res);
        end
        rst = 1'b0;
        @(negedge clk);
        check_run("after_reset", 16'd1, 16'd1, 500);
        drop_st();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        stale_cnt = 0;
        use_model = 1'b0;
        rst  = 1'b1;
        st   = 1'b0;
        in_v = 16'd0;
        n_v  = 16'd0;
        test_reset();
        test_basic();
        test_zero_count();
        test_wrap();
        test_random_latency();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
